mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/core101_pkg.sv | 15 +
 rtl/arb_starve_cnt.sv | 36 +++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core101_pkg.sv
// Shared encodings for the core101 memory arbiter: FSM states and transaction owner.
package core101_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WAIT_GNT = 2'b01,
      WAIT_RSP = 2'b10
   } arb_state_e;

   typedef enum logic {
      OWNER_IFU = 1'b0,
      OWNER_LSU = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive contested IFU losses; sat_o lets the IFU win the next contest.
module arb_starve_cnt #(
   parameter int LIMIT = 4
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   localparam int CntWidth = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
   localparam logic [CntWidth-1:0] CntMax = CntWidth'(LIMIT);

   logic [CntWidth-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != CntMax)) begin
         count_d = count_q + CntWidth'(1);
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign sat_o = (count_q == CntMax);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto a single-outstanding memory port, with
// starvation protection for the IFU and flush-based dropping of IFU responses.
module mem_arbiter
   import core101_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clock_in,
   input  logic                    reset_in,
   input  logic                    flush_in,
   input  logic                    ifu_req_in,
   input  logic [ADDR_WIDTH-1:0]   ifu_addr_in,
   output logic                    ifu_gnt_out,
   output logic                    ifu_rvalid_out,
   output logic [DATA_WIDTH-1:0]   ifu_rdata_out,
   input  logic                    lsu_req_in,
   input  logic                    lsu_we_in,
   input  logic [DATA_WIDTH/8-1:0] lsu_be_in,
   input  logic [ADDR_WIDTH-1:0]   lsu_addr_in,
   input  logic [DATA_WIDTH-1:0]   lsu_wdata_in,
   output logic                    lsu_gnt_out,
   output logic                    lsu_rvalid_out,
   output logic [DATA_WIDTH-1:0]   lsu_rdata_out,
   output logic                    mem_req_out,
   output logic                    mem_we_out,
   output logic [DATA_WIDTH/8-1:0] mem_be_out,
   output logic [ADDR_WIDTH-1:0]   mem_addr_out,
   output logic [DATA_WIDTH-1:0]   mem_wdata_out,
   input  logic                    mem_gnt_in,
   input  logic                    mem_rvalid_in,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_in,
   output logic                    busy_out
);

   localparam int BeWidth = DATA_WIDTH / 8;

   arb_state_e                state_q, state_d;
   arb_owner_e                owner_q, owner_d;
   logic                      dropFlag_q, dropFlag_d;
   logic                      afterReset_q;
   logic                      we_q, we_d;
   logic [BeWidth-1:0]        be_q, be_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;

   logic starveSat, starveInc, starveClr;
   logic arbEn, ifuEligible, bothReq, ifuWins, lsuWins;
   logic ifuRvalid, lsuRvalid;
   logic outGate;

   arb_starve_cnt #(
      .LIMIT(STARVE_LIMIT)
   ) uStarveCnt (
      .clock_i(clock_in),
      .reset_i(reset_in),
      .inc_i  (starveInc),
      .clr_i  (starveClr),
      .sat_o  (starveSat)
   );

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q      <= IDLE;
         owner_q      <= OWNER_IFU;
         dropFlag_q   <= 1'b0;
         afterReset_q <= 1'b1;
         we_q         <= 1'b0;
         be_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         dropFlag_q   <= dropFlag_d;
         afterReset_q <= 1'b0;
         we_q         <= we_d;
         be_q         <= be_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

   // Arbitration is held off in the cycle after reset so no grant can escape while outputs are forced low.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      dropFlag_d = dropFlag_q;
      we_d       = we_q;
      be_d       = be_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      ifuRvalid  = 1'b0;
      lsuRvalid  = 1'b0;

      arbEn       = (state_q == IDLE) && !afterReset_q;
      ifuEligible = ifu_req_in && !flush_in;
      bothReq     = ifuEligible && lsu_req_in;
      ifuWins     = arbEn && ifuEligible && (!lsu_req_in || starveSat);
      lsuWins     = arbEn && lsu_req_in && !ifuWins;
      starveInc   = lsuWins && bothReq;
      starveClr   = ifuWins;

      unique case (state_q)
         IDLE: begin
            dropFlag_d = 1'b0;
            if (ifuWins) begin
               state_d = WAIT_GNT;
               owner_d = OWNER_IFU;
               we_d    = 1'b0;
               be_d    = '1;
               addr_d  = ifu_addr_in;
               wdata_d = '0;
            end else if (lsuWins) begin
               state_d = WAIT_GNT;
               owner_d = OWNER_LSU;
               we_d    = lsu_we_in;
               be_d    = lsu_be_in;
               addr_d  = lsu_addr_in;
               wdata_d = lsu_wdata_in;
            end
         end
         WAIT_GNT: begin
            if (flush_in && (owner_q == OWNER_IFU)) begin
               dropFlag_d = 1'b1;
            end
            if (mem_gnt_in) begin
               state_d = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (mem_rvalid_in) begin
               state_d    = IDLE;
               dropFlag_d = 1'b0;
               lsuRvalid  = (owner_q == OWNER_LSU);
               ifuRvalid  = (owner_q == OWNER_IFU) && !dropFlag_q && !flush_in;
            end else if (flush_in && (owner_q == OWNER_IFU)) begin
               dropFlag_d = 1'b1;
            end
         end
         default: begin
            state_d    = IDLE;
            dropFlag_d = 1'b0;
         end
      endcase
   end

   assign outGate = reset_in || afterReset_q;

   assign ifu_gnt_out    = !outGate && ifuWins;
   assign lsu_gnt_out    = !outGate && lsuWins;
   assign ifu_rvalid_out = !outGate && ifuRvalid;
   assign lsu_rvalid_out = !outGate && lsuRvalid;
   assign ifu_rdata_out  = outGate ? '0 : mem_rdata_in;
   assign lsu_rdata_out  = outGate ? '0 : mem_rdata_in;
   assign mem_req_out    = !outGate && (state_q == WAIT_GNT);
   assign mem_we_out     = !outGate && we_q;
   assign mem_be_out     = outGate ? '0 : be_q;
   assign mem_addr_out   = outGate ? '0 : addr_q;
   assign mem_wdata_out  = outGate ? '0 : wdata_q;
   assign busy_out       = !outGate && (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

   localparam int AW          = 32;
   localparam int DW          = 32;
   localparam int StarveLimit = 4;

   logic          clock_in = 1'b0;
   logic          reset_in, flush_in;
   logic          ifu_req_in;
   logic [AW-1:0] ifu_addr_in;
   logic          ifu_gnt_out, ifu_rvalid_out;
   logic [DW-1:0] ifu_rdata_out;
   logic          lsu_req_in, lsu_we_in;
   logic [3:0]    lsu_be_in;
   logic [AW-1:0] lsu_addr_in;
   logic [DW-1:0] lsu_wdata_in;
   logic          lsu_gnt_out, lsu_rvalid_out;
   logic [DW-1:0] lsu_rdata_out;
   logic          mem_req_out, mem_we_out;
   logic [3:0]    mem_be_out;
   logic [AW-1:0] mem_addr_out;
   logic [DW-1:0] mem_wdata_out;
   logic          mem_gnt_in, mem_rvalid_in;
   logic [DW-1:0] mem_rdata_in;
   logic          busy_out;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      bit          rst, fl, ireq, lreq, lwe, mgnt, mrv;
      logic [31:0] iaddr, laddr, lwdata, mrdata;
      logic [3:0]  lbe;
   } stim_t;

   // Transaction-level model: at most one outstanding request plus a loss tally for the IFU.
   bit          mBusy = 0, mAccepted = 0, mDropped = 0, mOwnerLsu = 0, mFresh = 0, mWe = 0;
   logic [31:0] mAddr = '0, mWdata = '0;
   logic [3:0]  mBe = '0;
   int          mLosses = 0;

   mem_arbiter #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .STARVE_LIMIT(StarveLimit)
   ) dut (
      .clock_in      (clock_in),
      .reset_in      (reset_in),
      .flush_in      (flush_in),
      .ifu_req_in    (ifu_req_in),
      .ifu_addr_in   (ifu_addr_in),
      .ifu_gnt_out   (ifu_gnt_out),
      .ifu_rvalid_out(ifu_rvalid_out),
      .ifu_rdata_out (ifu_rdata_out),
      .lsu_req_in    (lsu_req_in),
      .lsu_we_in     (lsu_we_in),
      .lsu_be_in     (lsu_be_in),
      .lsu_addr_in   (lsu_addr_in),
      .lsu_wdata_in  (lsu_wdata_in),
      .lsu_gnt_out   (lsu_gnt_out),
      .lsu_rvalid_out(lsu_rvalid_out),
      .lsu_rdata_out (lsu_rdata_out),
      .mem_req_out   (mem_req_out),
      .mem_we_out    (mem_we_out),
      .mem_be_out    (mem_be_out),
      .mem_addr_out  (mem_addr_out),
      .mem_wdata_out (mem_wdata_out),
      .mem_gnt_in    (mem_gnt_in),
      .mem_rvalid_in (mem_rvalid_in),
      .mem_rdata_in  (mem_rdata_in),
      .busy_out      (busy_out)
   );

   always #5 clock_in = ~clock_in;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic stim_t noStim();
      stim_t s;
      s.rst = 0; s.fl = 0; s.ireq = 0; s.lreq = 0; s.lwe = 0; s.mgnt = 0; s.mrv = 0;
      s.iaddr = '0; s.laddr = '0; s.lwdata = '0; s.mrdata = '0; s.lbe = '0;
      return s;
   endfunction

   // Compares every output against the model, then advances the model across the coming edge.
   task automatic checkOutput();
      bit gate, ifuOk;
      bit eIfuGnt, eLsuGnt, eIfuRv, eLsuRv, eMemReq, eBusy;
      gate = reset_in || mFresh;
      ifuOk = 0; eIfuGnt = 0; eLsuGnt = 0; eIfuRv = 0; eLsuRv = 0; eMemReq = 0; eBusy = 0;
      if (!gate) begin
         if (!mBusy) begin
            ifuOk = ifu_req_in && !flush_in;
            if (lsu_req_in && !(ifuOk && mLosses == StarveLimit)) eLsuGnt = 1;
            else if (ifuOk) eIfuGnt = 1;
         end else if (!mAccepted) begin
            eMemReq = 1;
         end else if (mem_rvalid_in) begin
            if (mOwnerLsu) eLsuRv = 1;
            else eIfuRv = !mDropped && !flush_in;
         end
         eBusy = mBusy;
      end
      cmp("ifu_gnt", 64'(ifu_gnt_out), 64'(eIfuGnt));
      cmp("lsu_gnt", 64'(lsu_gnt_out), 64'(eLsuGnt));
      cmp("ifu_rvalid", 64'(ifu_rvalid_out), 64'(eIfuRv));
      cmp("lsu_rvalid", 64'(lsu_rvalid_out), 64'(eLsuRv));
      cmp("mem_req", 64'(mem_req_out), 64'(eMemReq));
      cmp("busy", 64'(busy_out), 64'(eBusy));
      cmp("ifu_rdata", 64'(ifu_rdata_out), gate ? 64'd0 : 64'(mem_rdata_in));
      cmp("lsu_rdata", 64'(lsu_rdata_out), gate ? 64'd0 : 64'(mem_rdata_in));
      if (eMemReq) begin
         cmp("mem_addr", 64'(mem_addr_out), 64'(mAddr));
         cmp("mem_we", 64'(mem_we_out), 64'(mWe));
         if (mOwnerLsu) begin
            cmp("mem_be", 64'(mem_be_out), 64'(mBe));
            cmp("mem_wdata", 64'(mem_wdata_out), 64'(mWdata));
         end
      end
      if (reset_in) begin
         mBusy = 0; mLosses = 0; mDropped = 0; mFresh = 1;
      end else begin
         if (!mFresh) begin
            if (!mBusy) begin
               if (eLsuGnt || eIfuGnt) begin
                  mBusy = 1; mAccepted = 0; mDropped = 0; mOwnerLsu = eLsuGnt;
                  mAddr  = eLsuGnt ? lsu_addr_in : ifu_addr_in;
                  mWe    = eLsuGnt ? lsu_we_in : 1'b0;
                  mBe    = lsu_be_in;
                  mWdata = lsu_wdata_in;
                  if (eIfuGnt) mLosses = 0;
                  else if (ifuOk && mLosses < StarveLimit) mLosses++;
               end
            end else if (!mAccepted) begin
               if (flush_in && !mOwnerLsu) mDropped = 1;
               if (mem_gnt_in) mAccepted = 1;
            end else begin
               if (mem_rvalid_in) mBusy = 0;
               else if (flush_in && !mOwnerLsu) mDropped = 1;
            end
         end
         mFresh = 0;
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      @(negedge clock_in);
      reset_in = s.rst; flush_in = s.fl;
      ifu_req_in = s.ireq; ifu_addr_in = s.iaddr;
      lsu_req_in = s.lreq; lsu_we_in = s.lwe; lsu_be_in = s.lbe;
      lsu_addr_in = s.laddr; lsu_wdata_in = s.lwdata;
      mem_gnt_in = s.mgnt; mem_rvalid_in = s.mrv; mem_rdata_in = s.mrdata;
      #2;
      checkOutput();
   endtask

   task automatic idleCycle();
      applyStimulus(noStim());
   endtask

   initial begin
      stim_t s;
      bit    grantSeq[10];
      int    nGrants;

      reset_in = 1; flush_in = 0; ifu_req_in = 0; ifu_addr_in = '0;
      lsu_req_in = 0; lsu_we_in = 0; lsu_be_in = '0; lsu_addr_in = '0; lsu_wdata_in = '0;
      mem_gnt_in = 0; mem_rvalid_in = 0; mem_rdata_in = '0;

      s = noStim(); s.rst = 1; s.ireq = 1; s.lreq = 1; s.mrdata = 32'h5555_AAAA;
      applyStimulus(s);
      applyStimulus(s);
      cmp("reset_busy", 64'(busy_out), 64'd0);
      cmp("reset_rdata", 64'(ifu_rdata_out), 64'd0);
      s.rst = 0;
      applyStimulus(s);
      cmp("post_reset_gnt", 64'(ifu_gnt_out | lsu_gnt_out), 64'd0);
      idleCycle();

      // Single IFU read with immediate memory grant.
      s = noStim(); s.ireq = 1; s.iaddr = 32'h100;
      applyStimulus(s);
      cmp("ifu_read_gnt", 64'(ifu_gnt_out), 64'd1);
      s = noStim(); s.mgnt = 1;
      applyStimulus(s);
      cmp("ifu_read_memreq", 64'(mem_req_out), 64'd1);
      cmp("ifu_read_addr", 64'(mem_addr_out), 64'h100);
      s = noStim(); s.mrv = 1; s.mrdata = 32'hDEAD_BEEF;
      applyStimulus(s);
      cmp("ifu_read_rvalid", 64'(ifu_rvalid_out), 64'd1);
      cmp("ifu_read_rdata", 64'(ifu_rdata_out), 64'hDEAD_BEEF);
      idleCycle();
      cmp("ifu_read_idle", 64'(busy_out), 64'd0);

      // LSU write with memory grant arriving on the third request cycle.
      s = noStim(); s.lreq = 1; s.lwe = 1; s.lbe = 4'b0011; s.laddr = 32'h200; s.lwdata = 32'h1234;
      applyStimulus(s);
      cmp("lsu_write_gnt", 64'(lsu_gnt_out), 64'd1);
      for (int i = 0; i < 3; i++) begin
         s = noStim(); s.mgnt = (i == 2); s.mrv = (i == 0);
         applyStimulus(s);
         cmp("lsu_write_memreq", 64'(mem_req_out), 64'd1);
         cmp("lsu_write_fields", {mem_we_out, mem_be_out, mem_addr_out, mem_wdata_out},
             {1'b1, 4'b0011, 32'h200, 32'h1234});
      end
      s = noStim(); s.mrv = 1; s.mrdata = 32'h0BAD_F00D;
      applyStimulus(s);
      cmp("lsu_write_rvalid", 64'(lsu_rvalid_out), 64'd1);
      cmp("lsu_write_ifu_rvalid", 64'(ifu_rvalid_out), 64'd0);
      idleCycle();

      // Continuous contention: four LSU wins, then the IFU, repeating.
      nGrants = 0;
      for (int c = 0; c < 36 && nGrants < 10; c++) begin
         s = noStim(); s.ireq = 1; s.lreq = 1; s.iaddr = 32'h400 + 32'(c); s.laddr = 32'h800 + 32'(c);
         s.mgnt = 1; s.mrv = 1; s.mrdata = 32'(c);
         applyStimulus(s);
         if (ifu_gnt_out || lsu_gnt_out) begin
            grantSeq[nGrants] = lsu_gnt_out;
            nGrants++;
         end
      end
      cmp("contention_count", 64'(nGrants), 64'd10);
      for (int k = 0; k < nGrants; k++) begin
         cmp("contention_order", 64'(grantSeq[k]), (k % 5 == 4) ? 64'd0 : 64'd1);
      end
      idleCycle();
      idleCycle();

      // IFU fetch flushed while waiting for its response, then a clean fetch.
      s = noStim(); s.ireq = 1; s.iaddr = 32'h300;
      applyStimulus(s);
      s = noStim(); s.mgnt = 1;
      applyStimulus(s);
      s = noStim(); s.fl = 1;
      applyStimulus(s);
      idleCycle();
      s = noStim(); s.mrv = 1; s.mrdata = 32'hCAFE;
      applyStimulus(s);
      cmp("flush_rvalid", 64'(ifu_rvalid_out), 64'd0);
      idleCycle();
      cmp("flush_idle", 64'(busy_out), 64'd0);
      s = noStim(); s.ireq = 1; s.iaddr = 32'h304;
      applyStimulus(s);
      s = noStim(); s.mgnt = 1;
      applyStimulus(s);
      s = noStim(); s.mrv = 1; s.mrdata = 32'h600D;
      applyStimulus(s);
      cmp("refetch_rvalid", 64'(ifu_rvalid_out), 64'd1);

      // Flush in IDLE blocks the IFU but lets the LSU through.
      s = noStim(); s.ireq = 1; s.lreq = 1; s.fl = 1; s.laddr = 32'h500;
      applyStimulus(s);
      cmp("idle_flush_gnts", {ifu_gnt_out, lsu_gnt_out}, 64'b01);
      s = noStim(); s.mgnt = 1;
      applyStimulus(s);
      s = noStim(); s.mrv = 1;
      applyStimulus(s);

      // Reset while the LSU request waits for a memory grant.
      s = noStim(); s.lreq = 1; s.laddr = 32'h700;
      applyStimulus(s);
      s = noStim(); s.rst = 1;
      applyStimulus(s);
      cmp("reset_mid_memreq", 64'(mem_req_out), 64'd0);
      s = noStim(); s.mrv = 1;
      applyStimulus(s);
      cmp("reset_mid_state", {busy_out, mem_req_out, lsu_rvalid_out, ifu_rvalid_out}, 64'd0);
      s = noStim(); s.lreq = 1; s.laddr = 32'h704;
      applyStimulus(s);
      cmp("reset_recover_gnt", 64'(lsu_gnt_out), 64'd1);

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         s.rst    = ($urandom_range(0, 99) == 0);
         s.fl     = ($urandom_range(0, 9) == 0);
         s.ireq   = ($urandom_range(0, 9) < 6);
         s.lreq   = ($urandom_range(0, 1) == 1);
         s.lwe    = ($urandom_range(0, 1) == 1);
         s.mgnt   = ($urandom_range(0, 1) == 1);
         s.mrv    = ($urandom_range(0, 9) < 4);
         s.iaddr  = $urandom; s.laddr = $urandom;
         s.lwdata = $urandom; s.mrdata = $urandom;
         s.lbe    = 4'($urandom);
         applyStimulus(s);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
